// File: rtl/qtr_sampler_if.sv
// Control/result bundle between the QTR sampler and the maze controller.
// Signal names match the legacy flat port list.
interface qtr_sampler_if;
  logic [7:0]  channel_sel;
  logic        ir_evenLED;
  logic        ir_oddLED;
  logic [16:0] ttd0;
  logic [16:0] ttd1;
  logic [16:0] ttd2;
  logic [16:0] ttd3;
  logic [16:0] ttd4;
  logic [16:0] ttd5;
  logic [16:0] ttd6;
  logic [16:0] ttd7;
  logic        frame_done;
  logic        busy;

  modport master (
    output channel_sel,
    input  ir_evenLED, ir_oddLED,
    input  ttd0, ttd1, ttd2, ttd3, ttd4, ttd5, ttd6, ttd7,
    input  frame_done, busy
  );

  modport slave (
    input  channel_sel,
    output ir_evenLED, ir_oddLED,
    output ttd0, ttd1, ttd2, ttd3, ttd4, ttd5, ttd6, ttd7,
    output frame_done, busy
  );
endinterface

// File: rtl/qtr_sampler.sv
// QTR reflectance front end: charge the enabled lines, release them, and time the decay
// of each channel. Eight TTD words are published once per frame.
module qtr_sampler #(
  parameter int unsigned CHARGE_CYCLES = 160,
  parameter logic [16:0] TIMEOUT       = 17'd80000
) (
  input  logic         WF_CLK,
  input  logic         rst,
  inout  wire  [7:0]   ir_snsr,
  qtr_sampler_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CHARGE  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_UPDATE  = 2'd3;

  localparam int unsigned   CW       = $clog2(CHARGE_CYCLES + 1);
  localparam logic [CW-1:0] CHG_LAST = CW'(CHARGE_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] chg_q, chg_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [7:0]    en_q, en_d;
  logic [7:0]    done_q, done_d;
  logic [7:0]    sync1_q, sync1_d;
  logic [7:0]    sync2_q, sync2_d;
  logic [16:0]   shadow_q [8];
  logic [16:0]   shadow_d [8];
  logic [16:0]   ttd_q [8];
  logic [16:0]   ttd_d [8];
  logic          frame_done_q, frame_done_d;
  logic [7:0]    cap;
  logic          busy;

  assign sync1_d = ir_snsr;
  assign sync2_d = sync1_q;

  always_comb begin
    state_d      = state_q;
    chg_d        = chg_q;
    cnt_d        = cnt_q;
    en_d         = en_q;
    done_d       = done_q;
    shadow_d     = shadow_q;
    ttd_d        = ttd_q;
    frame_done_d = 1'b0;
    cap          = '0;
    case (state_q)
      S_IDLE: begin
        state_d = S_CHARGE;
        en_d    = bus.channel_sel;
        chg_d   = '0;
      end
      S_CHARGE: begin
        if (chg_q == CHG_LAST) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
        end else begin
          chg_d = chg_q + CW'(1);
        end
      end
      S_MEASURE: begin
        cap    = en_q & ~done_q & ~sync2_q;
        done_d = done_q | cap;
        for (int unsigned n = 0; n < 8; n++) begin
          if (cap[n]) shadow_d[n] = cnt_q;
        end
        // Exit test and result load use this cycle's captures, so ttd* and
        // frame_done both change on the edge leaving MEASURE.
        if ((done_d == en_q) || (cnt_q == TIMEOUT - 17'd1)) begin
          state_d      = S_UPDATE;
          frame_done_d = 1'b1;
          for (int unsigned n = 0; n < 8; n++) begin
            if (!en_q[n])       ttd_d[n] = '0;
            else if (done_d[n]) ttd_d[n] = shadow_d[n];
            else                ttd_d[n] = TIMEOUT;
          end
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      S_UPDATE: begin
        state_d = S_CHARGE;
        done_d  = '0;
        en_d    = bus.channel_sel;
        chg_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge WF_CLK or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      chg_q        <= '0;
      cnt_q        <= '0;
      en_q         <= '0;
      done_q       <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      frame_done_q <= 1'b0;
      for (int unsigned n = 0; n < 8; n++) begin
        shadow_q[n] <= '0;
        ttd_q[n]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      chg_q        <= chg_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      done_q       <= done_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      frame_done_q <= frame_done_d;
      for (int unsigned n = 0; n < 8; n++) begin
        shadow_q[n] <= shadow_d[n];
        ttd_q[n]    <= ttd_d[n];
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign ir_snsr[g] = ((state_q == S_CHARGE) && en_q[g]) ? 1'b1 : 1'bz;
  end

  assign busy           = (state_q == S_CHARGE) || (state_q == S_MEASURE);
  assign bus.busy       = busy;
  assign bus.ir_evenLED = busy && (|(en_q & 8'h55));
  assign bus.ir_oddLED  = busy && (|(en_q & 8'hAA));
  assign bus.frame_done = frame_done_q;
  assign bus.ttd0       = ttd_q[0];
  assign bus.ttd1       = ttd_q[1];
  assign bus.ttd2       = ttd_q[2];
  assign bus.ttd3       = ttd_q[3];
  assign bus.ttd4       = ttd_q[4];
  assign bus.ttd5       = ttd_q[5];
  assign bus.ttd6       = ttd_q[6];
  assign bus.ttd7       = ttd_q[7];

endmodule

// File: tb/tb_qtr_sampler.sv
// Directed frames for qtr_sampler; expected TTD vectors are queued per frame and
// compared by a monitor whenever frame_done is seen.
module tb_qtr_sampler;
  localparam logic [16:0] TMO = 17'd80000;
  localparam int          CHG = 160;

  typedef logic [7:0][16:0] ttd_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pull_low;
  wire  [7:0] ir_snsr;

  qtr_sampler_if bus ();

  qtr_sampler #(.CHARGE_CYCLES(CHG), .TIMEOUT(TMO)) dut (
    .WF_CLK (clk),
    .rst    (rst),
    .ir_snsr(ir_snsr),
    .bus    (bus)
  );

  // Charged capacitor holds the line high until the bench discharges it.
  for (genvar g = 0; g < 8; g++) begin : g_line
    pullup (ir_snsr[g]);
    assign ir_snsr[g] = pull_low[g] ? 1'b0 : 1'bz;
  end

  always #5 clk = ~clk;

  int       n_pass = 0;
  int       n_chk  = 0;
  ttd_vec_t exp_q[$];
  ttd_vec_t mon_e, mon_a;
  int       decay_at [8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic ttd_vec_t get_ttd();
    ttd_vec_t v;
    v[0] = bus.ttd0; v[1] = bus.ttd1; v[2] = bus.ttd2; v[3] = bus.ttd3;
    v[4] = bus.ttd4; v[5] = bus.ttd5; v[6] = bus.ttd6; v[7] = bus.ttd7;
    return v;
  endfunction

  always @(negedge clk) begin
    if (bus.frame_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = get_ttd();
        for (int n = 0; n < 8; n++) check($sformatf("ttd%0d", n), int'(mon_a[n]), int'(mon_e[n]));
      end
    end
  end

  task automatic set_decay(input int d0, input int d1, input int d2, input int d3,
                           input int d4, input int d5, input int d6, input int d7);
    decay_at[0] = d0; decay_at[1] = d1; decay_at[2] = d2; decay_at[3] = d3;
    decay_at[4] = d4; decay_at[5] = d5; decay_at[6] = d6; decay_at[7] = d7;
  endtask

  // Called in IDLE or UPDATE; decay_at[n] < 0 means the line never discharges.
  task automatic run_frame(input string tag, input logic [7:0] sel, input bit expect_done,
                           input int mid_cycle, input logic [7:0] mid_sel, input int rst_cycle);
    ttd_vec_t e;
    int  last, m_len, k, good_chg, good_led;
    bit  seen;
    logic exp_even, exp_odd;
    exp_even = |(sel & 8'h55);
    exp_odd  = |(sel & 8'hAA);
    bus.channel_sel = sel;
    pull_low = ~sel;
    last = 0;
    for (int n = 0; n < 8; n++) begin
      if (!sel[n]) begin
        e[n] = '0;
      end else if (decay_at[n] < 0 || decay_at[n] + 2 > int'(TMO) - 1) begin
        e[n] = TMO;
        last = int'(TMO) - 1;
      end else begin
        e[n] = 17'(decay_at[n] + 2);
        if (decay_at[n] + 2 > last) last = decay_at[n] + 2;
      end
    end
    m_len = last + 1;
    if (expect_done) exp_q.push_back(e);

    seen = 0;
    for (int w = 0; w < 400 && !seen; w++) begin
      @(posedge clk); #1;
      if (bus.busy) seen = 1;
    end
    check({tag, "_charge_start"}, int'(seen), 1);
    if (!seen) return;

    good_chg = 0;
    for (int c = 0; c < CHG; c++) begin
      if (ir_snsr === sel && bus.ir_evenLED == exp_even && bus.ir_oddLED == exp_odd && bus.busy)
        good_chg++;
      @(posedge clk); #1;
    end
    check({tag, "_charge_cycles"}, good_chg, CHG);

    seen = 0; k = 0; good_led = 0;
    while (!seen && k <= int'(TMO) + 200) begin
      if (bus.frame_done) begin
        seen = 1;
      end else begin
        if (k == rst_cycle) break;
        if (k == mid_cycle) bus.channel_sel = mid_sel;
        for (int n = 0; n < 8; n++)
          if (sel[n] && decay_at[n] >= 0 && k >= decay_at[n]) pull_low[n] = 1'b1;
        if (bus.busy && bus.ir_evenLED == exp_even && bus.ir_oddLED == exp_odd) good_led++;
        @(posedge clk); #1;
        k++;
      end
    end

    if (rst_cycle >= 0) begin
      rst = 1'b1;
      #1;
      mon_a = get_ttd();
      check({tag, "_rst_ttd_zero"}, int'(|mon_a), 0);
      check({tag, "_rst_flags"}, int'({bus.busy, bus.ir_evenLED, bus.ir_oddLED, bus.frame_done}), 0);
      pull_low = 8'h00;
      #1;
      check({tag, "_rst_lines_released"}, int'(ir_snsr), 8'hFF);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_rst_hold_no_done"}, int'(bus.frame_done), 0);
      rst = 1'b0;
    end else begin
      check({tag, "_measure_len"}, seen ? k : -1, m_len);
      check({tag, "_measure_led"}, good_led, m_len);
      check({tag, "_update_idle"}, int'({bus.busy, bus.ir_evenLED, bus.ir_oddLED}), 0);
      pull_low = 8'h00;
    end
  endtask

  initial begin
    rst = 1'b1;
    pull_low = 8'h00;
    bus.channel_sel = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    mon_a = get_ttd();
    check("reset_ttd_zero", int'(|mon_a), 0);
    check("reset_flags", int'({bus.busy, bus.ir_evenLED, bus.ir_oddLED, bus.frame_done}), 0);
    check("reset_lines_released", int'(ir_snsr), 8'hFF);
    rst = 1'b0;

    set_decay(10, 20, 30, 40, 50, 60, 70, 80);
    run_frame("basic", 8'hFF, 1'b1, -1, 8'h00, -1);

    set_decay(0, 0, 3, 0, 40, 0, 7, 0);
    run_frame("drive55", 8'h55, 1'b1, -1, 8'h00, -1);

    set_decay(5, 5, 5, 5, 5, 5, 5, 5);
    run_frame("none", 8'h00, 1'b1, -1, 8'h00, -1);

    set_decay(15, 25, 0, 0, 35, 45, 0, 0);
    run_frame("midsel_old", 8'h33, 1'b1, 5, 8'hCC, -1);

    set_decay(0, 0, 60, 5, 0, 0, 30, 12);
    run_frame("midsel_new", 8'hCC, 1'b1, -1, 8'h00, -1);

    set_decay(10, 20, 30, 40, 50, 60, 70, 80);
    run_frame("rst_mid", 8'hFF, 1'b0, -1, 8'h00, 20);

    set_decay(0, 33, 0, 1, 0, 20, 0, 9);
    run_frame("after_rst", 8'hAA, 1'b1, -1, 8'h00, -1);

    set_decay(100, 100, -1, 100, 0, 0, 0, 0);
    run_frame("timeout", 8'h0F, 1'b1, -1, 8'h00, -1);

    bus.channel_sel = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/qtr_sampler.md
# qtr_sampler

Front-end sampler for the 8-channel QTR-style reflectance array. It charges each sensor's capacitor, releases the line and measures time-to-decay (TTD) per channel. It then publishes eight 17-bit TTD words once per frame. It sits directly upstream of the maze controller, which thresholds the TTD words into black/white line colours and uses their min/max for calibration.

## Interface
Parameters:
- `CHARGE_CYCLES`, default 160: clocks the sensor lines are driven high (10 µs at 16 MHz).
- `TIMEOUT`, default 17'd80000: maximum measure length in clocks (5 ms); also the value reported for a channel that never decays.

Ports (clock and reset first):
- `WF_CLK` in 1: system clock (16 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `channel_sel` in 8: per-channel enable, sampled at the start of CHARGE.
- `ir_snsr` inout 8: sensor lines; bit n is channel n.
- `ir_evenLED` out 1: emitter enable for channels 0, 2, 4, 6.
- `ir_oddLED` out 1: emitter enable for channels 1, 3, 5, 7.
- `ttd0`…`ttd7` out 17 each: last completed TTD per channel, in clocks.
- `frame_done` out 1: one-cycle pulse when `ttd*` update.
- `busy` out 1: high in CHARGE and MEASURE.

## Operation
- **Clock and reset.** One clock domain: `WF_CLK`. Reset is asynchronous and active-high: `rst`.
- **State machine.** States are IDLE, CHARGE, MEASURE and UPDATE. Reset enters IDLE.
  - IDLE → CHARGE after one cycle, unconditionally.
- **CHARGE.**
  - On entry, latch `channel_sel` into `en_q`.
  - Drive `ir_snsr[n]`=1 for each n with `en_q[n]`=1. All other bits are high-Z.
  - Hold for exactly `CHARGE_CYCLES` cycles, then go to MEASURE.
- **MEASURE.**
  - All `ir_snsr` bits are high-Z.
  - Counter `cnt` is 0 on the first MEASURE cycle and increments by 1 per cycle.
  - Each pin passes through a 2-flop synchronizer.
  - For each enabled channel not yet captured: on the first cycle its synchronized value is 0, store `cnt` into `shadow[n]` and set `done[n]`.
  - Exit to UPDATE when `done == en_q` (all enabled channels captured) or when `cnt == TIMEOUT-1`, whichever comes first.
  - If both conditions hold in the same cycle, the captures made that cycle still count.
- **UPDATE (one cycle).**
  - `ttdn` = `shadow[n]` if `done[n]`.
  - `ttdn` = `TIMEOUT` if enabled but not done.
  - `ttdn` = 0 if disabled.
  - Assert `frame_done`, clear `done`, then go to CHARGE.
- **Emitters.**
  - `ir_evenLED` is high in CHARGE and MEASURE if any of `en_q[0,2,4,6]` is set.
  - `ir_oddLED` is the same for `en_q[1,3,5,7]`.
  - Both are low in IDLE and UPDATE.
- **No channels enabled.** If `channel_sel`=0, then `done == en_q` holds immediately. MEASURE lasts one cycle and all `ttd*` = 0.
- **Width rules.**
  - `cnt` is 17 bits and never exceeds `TIMEOUT-1`, so it cannot wrap.
  - `TIMEOUT` must be < 2^17.
  - The CHARGE counter is sized to hold `CHARGE_CYCLES`.
- **Frame-to-frame.** `channel_sel` changes mid-frame take effect at the next CHARGE entry only. Outputs are stable between `frame_done` pulses.

## Timing
- **Reset values.**
  - `ttd0`…`ttd7` = 0.
  - `frame_done`, `busy`, `ir_evenLED`, `ir_oddLED` = 0.
  - `ir_snsr` = high-Z.
  - `en_q` = 0, `done` = 0, synchronizers = 0.
- **Reset mid-frame.** Asserting `rst` at any point aborts the frame immediately:
  - lines are released and LEDs go low;
  - `ttd*` return to 0;
  - no `frame_done` pulse is issued.
- **Frame length.** 1 + `CHARGE_CYCLES` + M + 1 cycles, where M is the MEASURE length (1…`TIMEOUT`). The leading 1 is IDLE and applies to the first frame only; later frames are `CHARGE_CYCLES` + M + 1.
- **Synchronizer latency.**
  - Reported TTD equals true decay cycle + 2.
  - Pins already low on the first MEASURE cycle report 2.
  - The downstream threshold absorbs this fixed offset.
- **Output update.** `ttd*` change on the same clock edge that raises `frame_done`.
- **Line release.** High-Z takes effect on the first MEASURE cycle; there is no overlap between drive and measure.

## Test plan
- **Basic decay.** Reset, `channel_sel`=8'hFF, bench pulls `ir_snsr[n]` low at MEASURE cycle 10·(n+1) → `ttdn` = 10·(n+1)+2, `frame_done` at MEASURE cycle 82.
- **Timeout.** `channel_sel`=8'h0F, channel 2 never decays, others decay at 100 → `ttd2`=80000, `ttd0,1,3`=102, `ttd4`–`ttd7`=0; MEASURE lasts exactly 80000 cycles.
- **Drive check.** During CHARGE with `channel_sel`=8'h55 → `ir_snsr`=Z1Z1Z1Z1 (bits 7..0), `ir_evenLED`=1, `ir_oddLED`=0, for exactly 160 cycles.
- **No channels.** `channel_sel`=0 → frame of 160+1+1 cycles, all `ttd*`=0, both LEDs low.
- **Mid-frame select change.** Change `channel_sel` during MEASURE → current frame uses the old mask; the next frame uses the new mask.
- **Reset mid-MEASURE.** Assert `rst` mid-MEASURE → `ttd*`=0 at once, no `frame_done`; after release, a normal frame resumes from IDLE.
